pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencing controller for the pipeline registers (IF/ID, ID/EX control stage, EX/MEM).
//  Detects load-use hazards, taken-branch redirects and data-memory wait, and drives the
//  register write-enables and flushes. A flush forces the control stage to its reset pattern
//  (opcode 7'b0000000, func3 3'b000, subsra 0).
//  Keeps saturating stall/flush event counters and a sticky memory-wait timeout flag.
// PARAMETERS
//  CNT_W     16   width of the stall_cnt and flush_cnt event counters
//  MAX_WAIT  255  longest memory-wait run, in cycles, before timeout_err is set
// PORTS
//  clk             in   1   clock; state updates on the falling edge, same edge as the pipeline registers
//  reset           in   1   synchronous, active-high
//  id_rs1          in   5   source register 1 of the instruction in ID
//  id_rs2          in   5   source register 2 of the instruction in ID
//  id_use_rs1      in   1   ID instruction reads rs1
//  id_use_rs2      in   1   ID instruction reads rs2
//  ex_opcode       in   7   opcode held in the ID/EX control stage
//  ex_rd           in   5   destination register of the EX instruction
//  ex_branch_taken in   1   EX resolved a taken branch or jump
//  mem_busy        in   1   data memory not ready this cycle
//  pc_we           out  1   PC update enable
//  pc_sel_target   out  1   1 selects the branch target for the PC, 0 selects PC+4
//  ifid_we         out  1   IF/ID write enable
//  ifid_flush      out  1   load NOP into IF/ID
//  idex_we         out  1   ID/EX write enable
//  idex_flush      out  1   load reset pattern (bubble) into ID/EX control stage
//  exmem_we        out  1   EX/MEM write enable
//  stall_cnt       out  CNT_W  load-use stall cycles plus memory-wait cycles, saturating
//  flush_cnt       out  CNT_W  taken-branch flush events, saturating
//  timeout_err     out  1   sticky; set when a memory wait reaches MAX_WAIT cycles
//  state           out  2   current FSM state, for debug
// BEHAVIOUR
//  - Reset: state=RUN; counters=0; timeout_err=0; wait counter=0.
//    While reset=1 all write-enables=1, both flushes=1 and pc_sel_target=0.
//  - Hazard signals are combinational from the current state and inputs; state and counters
//    update on the falling edge.
//  - load_use = (ex_opcode==7'b0000011) && ex_rd!=0 &&
//    ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
//  - Default (no event): all _we=1, all flushes=0, pc_sel_target=0.
//  - Priority in every state: mem_busy > ex_branch_taken > load_use.
//  - States:
//    - RUN:
//      - mem_busy: all _we=0; go to MEM_WAIT; stall_cnt+1.
//      - else ex_branch_taken: pc_sel_target=1, ifid_flush=1, idex_flush=1; go to FLUSH; flush_cnt+1.
//      - else load_use: pc_we=0, ifid_we=0, idex_flush=1; go to LU_STALL; stall_cnt+1.
//    - LU_STALL: exactly one bubble. The EX opcode is now the bubble, so load_use is false.
//      Default outputs; go to RUN. A branch or mem_busy here is handled as in RUN.
//    - FLUSH: one recovery cycle, default outputs; go to RUN. mem_busy here is handled as in RUN.
//      A second taken branch here is ignored, because the EX instruction is the flushed bubble.
//    - MEM_WAIT:
//      - all _we=0 while mem_busy=1; stall_cnt+1 per cycle; wait counter+1.
//      - wait counter reaching MAX_WAIT sets timeout_err; the wait continues.
//      - mem_busy=0: default outputs, wait counter cleared, go to RUN.
//      - A branch or load-use pending on release is serviced in the next RUN cycle.
//  - Counters stop at all-ones and never wrap.
//  - The wait counter saturates at MAX_WAIT.
//  - Reset asserted mid-stall or mid-wait: state returns to RUN on that edge and all
//    counters and flags are cleared.
// STRUCTURE
//  - Shared package: state encoding (RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3) and opcode
//    constants (OP_LOAD=7'b0000011, OP_NOP=7'b0000000).
//  - Sub-module sat_counter #(W): enable, synchronous clear, saturating increment.
//    Used three times: stall_cnt, flush_cnt, wait counter.
// TESTING
//  1. Load x5 in EX (ex_opcode=0000011, ex_rd=5), ID reads rs1=5 ->
//     1 cycle with pc_we=0, ifid_we=0, idex_flush=1; then RUN; stall_cnt=1.
//  2. Same load with ex_rd=0, or id_use_rs1=0 -> no stall; stall_cnt stays 0.
//  3. ex_branch_taken=1 together with load_use=1 ->
//     pc_sel_target=1, ifid_flush=1, idex_flush=1, pc_we=1; flush_cnt=1; stall_cnt=0.
//  4. mem_busy high for 4 cycles alongside a taken branch ->
//     all _we=0 for 4 cycles; stall_cnt=4; the branch flush happens in the cycle after release.
//  5. MAX_WAIT=3, mem_busy held for 5 cycles -> timeout_err=1 from cycle 3 and held after release.
//  6. CNT_W=2, 5 load-use stalls -> stall_cnt=3. Reset in MEM_WAIT ->
//     next edge state=RUN, counters=0, timeout_err=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared definitions for the pipeline hazard controller:
//               FSM state encoding, opcode constants and the load-use
//               detection helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  // A load in EX whose destination is read by the instruction in ID.
  // x0 is never a real dependency, so ex_rd==0 never stalls.
  function automatic logic is_load_use(
    input logic [6:0] ex_opcode,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       id_use_rs1,
    input logic       id_use_rs2
  );
    return (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) ||
            (id_use_rs2 && (id_rs2 == ex_rd)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with enable and synchronous clear.
//               Counts on the falling edge, stops at MAX and never wraps.
// Ports       : clk   - clock (falling edge active)
//               i_clr - synchronous clear, wins over i_en
//               i_en  - increment enable
//               o_cnt - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(negedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Sequencing controller for the IF/ID, ID/EX and EX/MEM
//               pipeline registers. Detects load-use hazards, taken-branch
//               redirects and data-memory wait, drives the register write
//               enables and flushes, and keeps saturating stall/flush event
//               counters plus a sticky memory-wait timeout flag.
// Ports       : clk, reset         - falling-edge clock, sync active-high reset
//               id_*               - source operands of the ID instruction
//               ex_*               - opcode/rd/branch outcome of EX instruction
//               mem_busy           - data memory not ready
//               pc_we, pc_sel_target, ifid_we/flush, idex_we/flush, exmem_we
//                                  - pipeline register controls
//               stall_cnt, flush_cnt, timeout_err, state - status/debug
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [6:0]       ex_opcode,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             pc_sel_target,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err,
  output logic [1:0]       state
);

  import pipe_hazard_ctrl_pkg::*;

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            r_state;
  logic              r_timeout;
  logic [WAIT_W-1:0] w_wait_cnt;

  logic w_load_use;
  logic w_take_br;
  logic w_take_lu;
  logic w_wait_hit;

  assign w_load_use = is_load_use(ex_opcode, ex_rd, id_rs1, id_rs2,
                                  id_use_rs1, id_use_rs2);

  // mem_busy outranks everything. A branch seen in FLUSH belongs to the
  // flushed bubble and one seen on MEM_WAIT release waits for the next RUN
  // cycle, so only RUN and LU_STALL redirect. Load-use is only acted on in
  // RUN; in the other states EX holds a bubble or the release cycle defers it.
  assign w_take_br = !mem_busy && ex_branch_taken &&
                     ((r_state == ST_RUN) || (r_state == ST_LU_STALL));
  assign w_take_lu = !mem_busy && !ex_branch_taken && w_load_use &&
                     (r_state == ST_RUN);

  // The wait counter counts every busy cycle of a run, including the first
  // one seen in RUN, so the flag fires once the run is MAX_WAIT cycles long.
  assign w_wait_hit = mem_busy && (w_wait_cnt >= WAIT_LAST);

  always_comb begin
    pc_we         = 1'b1;
    pc_sel_target = 1'b0;
    ifid_we       = 1'b1;
    ifid_flush    = 1'b0;
    idex_we       = 1'b1;
    idex_flush    = 1'b0;
    exmem_we      = 1'b1;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
    end else if (w_take_br) begin
      pc_sel_target = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
    end else if (w_take_lu) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_timeout <= 1'b0;
    end else begin
      if (mem_busy) begin
        r_state <= ST_MEM_WAIT;
      end else if (w_take_br) begin
        r_state <= ST_FLUSH;
      end else if (w_take_lu) begin
        r_state <= ST_LU_STALL;
      end else begin
        r_state <= ST_RUN;
      end
      if (w_wait_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .i_clr (reset),
    .i_en  (mem_busy || w_take_lu),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .i_clr (reset),
    .i_en  (w_take_br),
    .o_cnt (flush_cnt)
  );

  sat_counter #(.W(WAIT_W), .MAX(WAIT_MAX)) u_wait_cnt (
    .clk   (clk),
    .i_clr (reset || !mem_busy),
    .i_en  (mem_busy),
    .o_cnt (w_wait_cnt)
  );

  assign timeout_err = r_timeout;
  assign state       = r_state;

endmodule
`default_nettype wire
